// File: rtl/scratchpad_mem_port.sv
// Single-port word scratchpad with sub-word stores, sign/zero-extending loads and a fixed-latency response pulse.
// Optional MISALIGN_TRAP_EN: misaligned H/HU/W requests skip the array and respond with resp_err set.
module scratchpad_mem_port #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset,
    output logic        req_ready,
    input  logic        req_valid,
    input  logic [31:0] req_bits_addr,
    input  logic [31:0] req_bits_data,
    input  logic        req_bits_fcn,
    input  logic [2:0]  req_bits_typ,
    output logic        resp_valid,
`ifdef MISALIGN_TRAP_EN
    output logic        resp_err,
`endif
    output logic [31:0] resp_bits_data
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [2:0] TYP_B  = 3'd1;
    localparam logic [2:0] TYP_H  = 3'd2;
    localparam logic [2:0] TYP_BU = 3'd5;
    localparam logic [2:0] TYP_HU = 3'd6;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lo,
                                                 input logic [2:0] typ);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lo, 3'b000} +: 8];
        h = lo[1] ? word[31:16] : word[15:0];
        case (typ)
            TYP_B:   load_extract = {{24{b[7]}}, b};
            TYP_BU:  load_extract = {24'd0, b};
            TYP_H:   load_extract = {{16{h[15]}}, h};
            TYP_HU:  load_extract = {16'd0, h};
            default: load_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] lo, input logic [2:0] typ);
        logic [31:0] r;
        r = old;
        case (typ)
            TYP_B, TYP_BU: r[{lo, 3'b000} +: 8]        = data[7:0];
            TYP_H, TYP_HU: r[{lo[1], 4'b0000} +: 16]   = data[15:0];
            default:       r                           = data;
        endcase
        return r;
    endfunction

`ifdef MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] lo, input logic [2:0] typ);
        case (typ)
            TYP_B, TYP_BU: misaligned = 1'b0;
            TYP_H, TYP_HU: misaligned = lo[0];
            default:       misaligned = (lo != 2'b00);
        endcase
    endfunction
`endif

    logic [31:0]   mem_r [DEPTH];
    state_t        state_r;
    logic [CW-1:0] count_r;
    logic [AW+1:0] addr_r;
    logic [31:0]   data_r;
    logic          fcn_r;
    logic [2:0]    typ_r;
    logic          req_ready_r;
    logic          resp_valid_r;
    logic          resp_err_r;
    logic [31:0]   resp_data_r;

    logic          accept_s;
    logic          commit_s;
    logic          err_s;
    logic          wr_en_s;
    logic [AW+1:0] c_addr_s;
    logic [AW-1:0] c_idx_s;
    logic [31:0]   c_data_s;
    logic          c_fcn_s;
    logic [2:0]    c_typ_s;
    logic [31:0]   rd_word_s;
    logic          unused_s;

    // Select the request that commits to the array on this edge (live inputs when LATENCY is 1).
    always_comb begin
        accept_s = req_valid && req_ready_r;
        if (LATENCY == 1) begin
            c_addr_s = req_bits_addr[AW+1:0];
            c_data_s = req_bits_data;
            c_fcn_s  = req_bits_fcn;
            c_typ_s  = req_bits_typ;
            commit_s = accept_s;
        end else begin
            c_addr_s = addr_r;
            c_data_s = data_r;
            c_fcn_s  = fcn_r;
            c_typ_s  = typ_r;
            commit_s = (state_r == WAIT) && (count_r == {CW{1'b0}});
        end
        c_idx_s   = c_addr_s[AW+1:2];
        rd_word_s = mem_r[c_idx_s];
`ifdef MISALIGN_TRAP_EN
        err_s     = misaligned(c_addr_s[1:0], c_typ_s);
`else
        err_s     = 1'b0;
`endif
        wr_en_s   = commit_s && c_fcn_s && !err_s && reset;
    end

    // Array write port; contents deliberately carry no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[c_idx_s] <= store_merge(rd_word_s, c_data_s, c_addr_s[1:0], c_typ_s);
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            count_r      <= {CW{1'b0}};
            addr_r       <= {(AW+2){1'b0}};
            data_r       <= 32'd0;
            fcn_r        <= 1'b0;
            typ_r        <= 3'd0;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_data_r  <= 32'd0;
        end else begin
            resp_valid_r <= commit_s;
            resp_err_r   <= commit_s && err_s;
            if (commit_s) begin
                resp_data_r <= (c_fcn_s || err_s) ? 32'd0
                             : load_extract(rd_word_s, c_addr_s[1:0], c_typ_s);
            end
            case (state_r)
                IDLE, RESP: begin
                    if (accept_s) begin
                        addr_r <= req_bits_addr[AW+1:0];
                        data_r <= req_bits_data;
                        fcn_r  <= req_bits_fcn;
                        typ_r  <= req_bits_typ;
                        if (LATENCY == 1) begin
                            state_r     <= RESP;
                            req_ready_r <= 1'b1;
                        end else begin
                            state_r     <= WAIT;
                            count_r     <= CW'(LATENCY - 2);
                            req_ready_r <= 1'b0;
                        end
                    end else begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (count_r == {CW{1'b0}}) begin
                        state_r     <= RESP;
                        req_ready_r <= 1'b1;
                    end else begin
                        count_r     <= count_r - CW'(1);
                        req_ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready      = req_ready_r;
    assign resp_valid     = resp_valid_r;
    assign resp_bits_data = resp_data_r;
`ifdef MISALIGN_TRAP_EN
    assign resp_err       = resp_err_r;
    assign unused_s       = ^req_bits_addr[31:AW+2];
`else
    assign unused_s       = ^{req_bits_addr[31:AW+2], resp_err_r};
`endif

endmodule

// File: tb/tb_scratchpad_mem_port.sv
// Scoreboard bench: instance A (DEPTH 4096, LATENCY 1) and instance B (DEPTH 16, LATENCY 3).
module tb_scratchpad_mem_port;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    logic        a_ready, a_valid, a_fcn, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [2:0]  a_typ;
    logic        b_ready, b_valid, b_fcn, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [2:0]  b_typ;

    scratchpad_mem_port #(.DEPTH(4096), .LATENCY(LAT_A)) dut_a (
        .clock(clk), .reset(rst_n), .req_ready(a_ready), .req_valid(a_valid),
        .req_bits_addr(a_addr), .req_bits_data(a_wdata), .req_bits_fcn(a_fcn),
        .req_bits_typ(a_typ), .resp_valid(a_rvalid),
`ifdef MISALIGN_TRAP_EN
        .resp_err(a_err),
`endif
        .resp_bits_data(a_rdata)
    );

    scratchpad_mem_port #(.DEPTH(16), .LATENCY(LAT_B)) dut_b (
        .clock(clk), .reset(rst_n), .req_ready(b_ready), .req_valid(b_valid),
        .req_bits_addr(b_addr), .req_bits_data(b_wdata), .req_bits_fcn(b_fcn),
        .req_bits_typ(b_typ), .resp_valid(b_rvalid),
`ifdef MISALIGN_TRAP_EN
        .resp_err(b_err),
`endif
        .resp_bits_data(b_rdata)
    );

`ifndef MISALIGN_TRAP_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor for A: pops the scoreboard and checks timing, data, error flag and ready.
    always @(negedge clk) begin
        check("a_ready", {31'd0, a_ready}, 32'd1);
        if (a_rvalid !== 1'b0) begin
            if (qa.size() == 0) begin
                check("a_unexpected_resp", {31'd0, a_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_resp_cycle", cyc, e.at);
                check("a_resp_data", a_rdata, e.data);
                check("a_resp_err", {31'd0, a_err}, {31'd0, e.err});
            end
        end
    end

    // Response monitor for B.
    always @(negedge clk) begin
        if (b_rvalid !== 1'b0) begin
            if (qb.size() == 0) begin
                check("b_unexpected_resp", {31'd0, b_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_resp_cycle", cyc, e.at);
                check("b_resp_data", b_rdata, e.data);
                check("b_resp_err", {31'd0, b_err}, {31'd0, e.err});
            end
        end
    end

    task automatic req_a(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp, input logic experr);
        exp_t e;
        int   n;
        a_valid = 1'b1; a_fcn = fcn; a_typ = typ; a_addr = addr; a_wdata = data;
        n = 0;
        while (a_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check("a_accept_timeout", 32'd0, 32'd1);
        e.data = exp; e.err = experr; e.at = cyc + LAT_A;
        qa.push_back(e);
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic req_b(input logic fcn, input logic [2:0] typ, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp, input logic experr);
        exp_t e;
        int   n;
        b_valid = 1'b1; b_fcn = fcn; b_typ = typ; b_addr = addr; b_wdata = data;
        n = 0;
        while (b_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check("b_accept_timeout", 32'd0, 32'd1);
        e.data = exp; e.err = experr; e.at = cyc + LAT_B;
        qb.push_back(e);
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] mis_rd;
        logic [31:0] mis_rd_after;
        logic        mis_err;
`ifdef MISALIGN_TRAP_EN
        mis_rd = 32'd0;  mis_rd_after = 32'hCAFEBABE; mis_err = 1'b1;
`else
        mis_rd = 32'h5566AA44; mis_rd_after = 32'd0; mis_err = 1'b0;
`endif
        rst_n = 1'b0;
        a_valid = 1'b0; a_fcn = 1'b0; a_typ = 3'd3; a_addr = 32'd0; a_wdata = 32'd0;
        b_valid = 1'b0; b_fcn = 1'b0; b_typ = 3'd3; b_addr = 32'd0; b_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", {31'd0, a_ready}, 32'd1);
        check("rst_a_rvalid", {31'd0, a_rvalid}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_a_err", {31'd0, a_err}, 32'd0);
        check("rst_b_ready", {31'd0, b_ready}, 32'd1);
        check("rst_b_rdata", b_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // A: word write/read, back to back
        req_a(1'b1, 3'd3, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
        req_a(1'b0, 3'd3, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        req_a(1'b0, 3'd0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
        // A: sub-word loads
        req_a(1'b1, 3'd3, 32'h80, 32'h8001F07F, 32'd0, 1'b0);
        req_a(1'b0, 3'd1, 32'h80, 32'd0, 32'h0000007F, 1'b0);
        req_a(1'b0, 3'd1, 32'h81, 32'd0, 32'hFFFFFFF0, 1'b0);
        req_a(1'b0, 3'd5, 32'h81, 32'd0, 32'h000000F0, 1'b0);
        req_a(1'b0, 3'd1, 32'h83, 32'd0, 32'hFFFFFF80, 1'b0);
        req_a(1'b0, 3'd2, 32'h82, 32'd0, 32'hFFFF8001, 1'b0);
        req_a(1'b0, 3'd6, 32'h82, 32'd0, 32'h00008001, 1'b0);
        req_a(1'b0, 3'd2, 32'h80, 32'd0, 32'hFFFFF07F, 1'b0);
        // A: sub-word stores
        req_a(1'b1, 3'd3, 32'h40, 32'h11223344, 32'd0, 1'b0);
        req_a(1'b1, 3'd1, 32'h41, 32'h000000AA, 32'd0, 1'b0);
        req_a(1'b1, 3'd2, 32'h42, 32'h00005566, 32'd0, 1'b0);
        req_a(1'b0, 3'd3, 32'h40, 32'd0, 32'h5566AA44, 1'b0);
        req_a(1'b0, 3'd3, 32'h42, 32'd0, mis_rd, mis_err);
        // A: misaligned word write
        req_a(1'b1, 3'd3, 32'h20, 32'hCAFEBABE, 32'd0, 1'b0);
        req_a(1'b1, 3'd3, 32'h22, 32'd0, 32'd0, mis_err);
        req_a(1'b0, 3'd3, 32'h20, 32'd0, mis_rd_after, 1'b0);

        // B: wrap plus ready window and held request
        req_b(1'b1, 3'd3, 32'h44, 32'h12345678, 32'd0, 1'b0);
        check("b_ready_wait1", {31'd0, b_ready}, 32'd0);
        b_valid = 1'b1; b_fcn = 1'b0; b_typ = 3'd3; b_addr = 32'h04; b_wdata = 32'd0;
        @(posedge clk); #1;
        check("b_ready_wait2", {31'd0, b_ready}, 32'd0);
        @(posedge clk); #1;
        check("b_ready_resp", {31'd0, b_ready}, 32'd1);
        req_b(1'b0, 3'd3, 32'h04, 32'd0, 32'h12345678, 1'b0);
        req_b(1'b1, 3'd3, 32'h08, 32'h00000055, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        check("b_drained", qb.size(), 32'd0);

        // B: reset during WAIT drops the pending store and its response
        b_valid = 1'b1; b_fcn = 1'b1; b_typ = 3'd3; b_addr = 32'h08; b_wdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        b_valid = 1'b0;
        check("b_ready_inflight", {31'd0, b_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("b_ready_in_reset", {31'd0, b_ready}, 32'd1);
        check("b_rvalid_in_reset", {31'd0, b_rvalid}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("b_ready_after_reset", {31'd0, b_ready}, 32'd1);
        req_b(1'b0, 3'd3, 32'h08, 32'd0, 32'h00000055, 1'b0);

        repeat (8) @(posedge clk);
        #1;
        check("a_queue_empty", qa.size(), 32'd0);
        check("b_queue_empty", qb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scratchpad_mem_port.md
Name: scratchpad_mem_port

Overview:
- Single-port word-organised scratchpad memory.
- Sits directly downstream of the core's imem or dmem request/response port, one instance per port.
- Accepts one request at a time over a valid/ready handshake. Performs sub-word stores and sign/zero-extending loads.
- Returns a one-cycle response pulse a fixed LATENCY cycles after acceptance.

Parameters:
- DEPTH, 4096, number of 32-bit words; power of two, at least 4.
- LATENCY, 1, cycles from the acceptance edge to the resp_valid cycle; at least 1.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_ready  output  1  block can accept a request this cycle.
- req_valid  input  1  request present.
- req_bits_addr  input  32  byte address.
- req_bits_data  input  32  store data, right-aligned.
- req_bits_fcn  input  1  0 = read, 1 = write.
- req_bits_typ  input  3  1=B, 2=H, 3=W, 5=BU, 6=HU; any other code is treated as W.
- resp_valid  output  1  one-cycle response pulse; the consumer has no ready signal.
- resp_bits_data  output  32  load result; 0 for writes.
- resp_err  output  1  misaligned flag; exists only with MISALIGN_TRAP_EN.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, counter = 0, resp_valid = 0, resp_bits_data = 0, resp_err = 0, req_ready = 1.
  - Array contents are not reset.
- Acceptance occurs on a rising edge where req_valid && req_ready. At that edge addr, data, fcn and typ are latched. Requests presented while req_ready = 0 are ignored.
- FSM states:
  - IDLE: req_ready = 1. On acceptance, go to RESP if LATENCY = 1; otherwise go to WAIT with counter = LATENCY-2.
  - WAIT: req_ready = 0. While counter != 0, decrement. When counter = 0, go to RESP at the next edge.
  - RESP: resp_valid = 1 and req_ready = 1 for exactly this cycle. A new request may be accepted in this cycle; it then follows the IDLE transition rules. With no acceptance, return to IDLE.
- Array access commits at the edge that enters RESP:
  - The store write happens at that edge.
  - The read value is registered into resp_bits_data at that edge.
  - Consequence: a read accepted in a RESP cycle of a write to the same word returns the newly written data.
  - With LATENCY = 1, back-to-back throughput is 1 request per cycle.
- Word index = addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so accesses wrap modulo DEPTH*4 bytes.
- Stores:
  - B writes byte lane addr[1:0] with data[7:0].
  - H writes lanes {addr[1],0} and {addr[1],1} with data[15:0].
  - W writes all four lanes.
  - Unused lanes keep their old contents.
- Loads:
  - B/BU select byte lane addr[1:0]; H/HU select halfword addr[1].
  - B and H sign-extend from bit 7 / bit 15; BU and HU zero-extend.
  - W returns the full word.
- resp_bits_data is 0 in the RESP cycle of a write. resp_bits_data holds its value outside RESP, but consumers sample it only when resp_valid = 1.
- Misalignment without the macro: H ignores addr[0]; W ignores addr[1:0].
- Reset asserted mid-operation: the in-flight request is discarded, no resp_valid is emitted, and any store not yet committed is dropped.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- When defined:
  - Port resp_err exists.
  - An H/HU request with addr[0] = 1, or a W request with addr[1:0] != 0, performs no array write and no read.
  - Its response arrives on the normal LATENCY schedule with resp_err = 1 and resp_bits_data = 0.
  - resp_err = 0 for aligned requests and outside RESP.
- When not defined: no resp_err port; misaligned accesses are handled as described in Behaviour.

Test Plan:
- Reset, then W write addr 0x10 data 0xDEADBEEF, then W read 0x10 (LATENCY=1) -> write pulse returns data 0; read resp_valid one cycle after acceptance with 0xDEADBEEF; req_ready stays 1 throughout.
- Sub-word loads after word 0x80 = 0x8001F07F:
  - B read 0x80 -> 0x0000007F; B read 0x81 -> 0xFFFFFFF0; BU read 0x81 -> 0x000000F0.
  - H read 0x82 -> 0xFFFF8001; HU read 0x82 -> 0x00008001.
- Sub-word stores on word 0x40 = 0x11223344: B write 0x41 data 0xAA, then H write 0x42 data 0x5566, then W read 0x40 -> 0x5566AA44.
- LATENCY=3: accept at edge t -> resp_valid high only in cycle t+3; req_ready low in cycles t+1 and t+2; a req_valid held high during that window is accepted only in the RESP cycle.
- Wrap and reset (DEPTH=16):
  - W write addr 0x44 data 0x12345678, then read addr 0x04 -> 0x12345678.
  - Assert reset in a WAIT cycle -> no resp_valid; req_ready = 1 immediately after reset.
- MISALIGN_TRAP_EN: W write 0x20 = 0xCAFEBABE, then W write 0x22 data 0, then W read 0x20:
  - The misaligned write responds with resp_err = 1.
  - The read returns 0xCAFEBABE with resp_err = 0.
